joy_db9_serial_reader: RTL and testbench

//  Drives the Neptuno DB9 joystick shift-register chain (74HC165-style) and deserialises it

---
 rtl/joy_db9_serial_reader.sv | 153 +++++++++++++++
 tb/tb_joy_db9_serial_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db9_serial_reader.sv
// Neptuno DB9 joystick chain reader: drives LOAD/CLK/SELECT for a 74HC165 chain
// and deserialises two frames per poll into active-high 6-button pad words.
module joy_db9_serial_reader #(
   parameter int CLK_DIV      = 100,
   parameter int NBITS        = 16,
   parameter int SETTLE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       JOY_DATA,
   output logic       JOY_CLK,
   output logic       JOY_LOAD,
   output logic       JOY_SELECT,
   output logic [7:0] joy1,
   output logic [7:0] joy2,
   output logic       joy_valid
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
   localparam int BW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {
      S_SETTLE,
      S_LOAD,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    div_q, div_d;
   logic [SW-1:0]    set_q, set_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             phase_q, phase_d;
   logic [NBITS-1:0] sr_q, sr_d;
   logic [NBITS-1:0] hf_q, hf_d;
   logic             clk_q, clk_d;
   logic             load_q, load_d;
   logic             sel_q, sel_d;
   logic [7:0]       joy1_q, joy1_d;
   logic [7:0]       joy2_q, joy2_d;
   logic             valid_q, valid_d;
   logic             tick;

   // hi = select=1 byte (directions, B, C), lo = select=0 byte (A, start)
   function automatic logic [7:0] pad_word(input logic [7:0] hi,
                                           input logic [7:0] lo);
      return {lo[2], lo[3], hi[2], hi[3], hi[4], hi[5], hi[6], hi[7]};
   endfunction

   assign tick = (div_q == DW'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      set_d   = set_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      sr_d    = sr_q;
      hf_d    = hf_q;
      clk_d   = clk_q;
      load_d  = load_q;
      sel_d   = sel_q;
      joy1_d  = joy1_q;
      joy2_d  = joy2_q;
      valid_d = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_SETTLE: begin
               if (set_q == SW'(SETTLE_TICKS - 1)) begin
                  set_d   = '0;
                  load_d  = 1'b0;
                  state_d = S_LOAD;
               end else begin
                  set_d = set_q + 1'b1;
               end
            end
            S_LOAD: begin
               load_d  = 1'b1;
               bit_d   = '0;
               phase_d = 1'b0;
               state_d = S_SHIFT;
            end
            S_SHIFT: begin
               if (!phase_q) begin
                  sr_d    = {sr_q[NBITS-2:0], ~JOY_DATA};
                  phase_d = 1'b1;
                  clk_d   = 1'b1;
               end else begin
                  clk_d   = 1'b0;
                  phase_d = 1'b0;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BW'(NBITS - 1))
                     state_d = S_LATCH;
               end
            end
            S_LATCH: begin
               if (sel_q) begin
                  hf_d  = sr_q;
                  sel_d = 1'b0;
               end else begin
                  joy1_d  = pad_word(hf_q[15:8], sr_q[15:8]);
                  joy2_d  = pad_word(hf_q[7:0], sr_q[7:0]);
                  valid_d = 1'b1;
                  sel_d   = 1'b1;
               end
               set_d   = '0;
               state_d = S_SETTLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_SETTLE;
         div_q   <= '0;
         set_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         sr_q    <= '0;
         hf_q    <= '0;
         clk_q   <= 1'b0;
         load_q  <= 1'b1;
         sel_q   <= 1'b1;
         joy1_q  <= '0;
         joy2_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         set_q   <= set_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         sr_q    <= sr_d;
         hf_q    <= hf_d;
         clk_q   <= clk_d;
         load_q  <= load_d;
         sel_q   <= sel_d;
         joy1_q  <= joy1_d;
         joy2_q  <= joy2_d;
         valid_q <= valid_d;
      end
   end

   assign JOY_CLK    = clk_q;
   assign JOY_LOAD   = load_q;
   assign JOY_SELECT = sel_q;
   assign joy1       = joy1_q;
   assign joy2       = joy2_q;
   assign joy_valid  = valid_q;

endmodule

// File: tb/tb_joy_db9_serial_reader.sv
// Directed bench for joy_db9_serial_reader: instance 0 uses default timing,
// instance 1 runs CLK_DIV=1; both are fed by a 74HC165-style pad model.
module tb_joy_db9_serial_reader;

   logic        clk = 1'b0;
   logic        rstn [2];
   logic        jdata [2];
   logic        jclk [2];
   logic        jload [2];
   logic        jsel [2];
   logic [7:0]  j1 [2];
   logic [7:0]  j2 [2];
   logic        jv [2];

   logic [15:0] pat1 [2];
   logic [15:0] pat0 [2];
   logic        stuck [2];
   logic [15:0] sh [2];
   logic        mclk [2];

   int nchk = 0;
   int nfail = 0;
   int vio [2] = '{0, 0};
   int n;

   always #5 clk = ~clk;

   joy_db9_serial_reader u_a (
      .clk(clk), .reset_n(rstn[0]), .JOY_DATA(jdata[0]),
      .JOY_CLK(jclk[0]), .JOY_LOAD(jload[0]), .JOY_SELECT(jsel[0]),
      .joy1(j1[0]), .joy2(j2[0]), .joy_valid(jv[0])
   );

   joy_db9_serial_reader #(.CLK_DIV(1), .NBITS(16), .SETTLE_TICKS(4)) u_b (
      .clk(clk), .reset_n(rstn[1]), .JOY_DATA(jdata[1]),
      .JOY_CLK(jclk[1]), .JOY_LOAD(jload[1]), .JOY_SELECT(jsel[1]),
      .joy1(j1[1]), .joy2(j2[1]), .joy_valid(jv[1])
   );

   // Pad chain: parallel load while LOAD is low, shift on rising JOY_CLK
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!jload[i])
            sh[i] <= jsel[i] ? pat1[i] : pat0[i];
         else if (jclk[i] && !mclk[i])
            sh[i] <= {sh[i][14:0], 1'b1};
         mclk[i] <= jclk[i];
      end
   end

   assign jdata[0] = stuck[0] | sh[0][15];
   assign jdata[1] = stuck[1] | sh[1][15];

   // Frame protocol checker
   logic pl [2] = '{1'b1, 1'b1};
   logic pc [2] = '{1'b0, 1'b0};
   logic seen [2] = '{1'b0, 1'b0};
   logic armed [2] = '{1'b0, 1'b0};
   logic sref [2];
   int   rises [2] = '{0, 0};
   int   gap [2] = '{0, 0};
   int   div [2] = '{100, 1};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rstn[i]) begin
            seen[i]  = 1'b0;
            armed[i] = 1'b0;
         end else begin
            if (!jload[i] && jclk[i]) vio[i]++;
            if (!jload[i] && pl[i]) begin
               if (seen[i] && rises[i] != 16) vio[i]++;
               seen[i]  = 1'b1;
               armed[i] = 1'b1;
               sref[i]  = jsel[i];
               rises[i] = 0;
            end
            if (jclk[i] && !pc[i]) begin
               if (armed[i] && rises[i] > 0 && gap[i] != 2 * div[i]) vio[i]++;
               rises[i]++;
               gap[i] = 0;
            end
            gap[i]++;
            if (armed[i] && jsel[i] != sref[i] && (rises[i] < 16 || jclk[i]))
               vio[i]++;
         end
         pl[i] = jload[i];
         pc[i] = jclk[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(input int i, output int cnt);
      cnt = -1;
      for (int k = 1; k <= 12000; k++) begin
         @(posedge clk);
         #1;
         if (jv[i]) begin
            cnt = k;
            break;
         end
      end
   endtask

   initial begin
      logic ok;
      logic p;
      int   r;
      rstn  = '{1'b0, 1'b0};
      stuck = '{1'b0, 1'b0};
      pat1  = '{16'h7FFF, 16'h7FFF};
      pat0  = '{16'hF7FF, 16'hF7FF};

      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clk", 32'(jclk[0]), 32'd0);
      chk("rst_load", 32'(jload[0]), 32'd1);
      chk("rst_sel", 32'(jsel[0]), 32'd1);
      chk("rst_joy1", 32'(j1[0]), 32'd0);
      chk("rst_joy2", 32'(j2[0]), 32'd0);
      chk("rst_valid", 32'(jv[0]), 32'd0);
      rstn = '{1'b1, 1'b1};

      n  = -1;
      ok = 1'b1;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk);
         #1;
         if (!jload[0]) begin
            n = k;
            break;
         end
         if (jclk[0] || !jsel[0] || j1[0] != 0 || j2[0] != 0 || jv[0])
            ok = 1'b0;
      end
      chk("first_load_clk", 32'(n), 32'd400);
      chk("settle_stable", 32'(ok), 32'd1);

      // pad1 up + A
      wait_valid(0, n);
      chk("poll1_time", 32'(n), 32'd7200);
      chk("poll1_joy1", 32'(j1[0]), 32'h41);
      chk("poll1_joy2", 32'(j2[0]), 32'h00);
      @(posedge clk);
      #1;
      chk("valid_width", 32'(jv[0]), 32'd0);

      // mixed buttons on both pads
      pat1[0] = 16'hB3CF;
      pat0[0] = 16'hFBF7;
      wait_valid(0, n);
      chk("poll2_time", 32'(n), 32'd7599);
      chk("poll2_joy1", 32'(j1[0]), 32'hB2);
      chk("poll2_joy2", 32'(j2[0]), 32'h4C);

      // disconnected chain
      stuck[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(0, n);
         chk($sformatf("stuck%0d_time", k), 32'(n), 32'd7600);
         chk($sformatf("stuck%0d_joy1", k), 32'(j1[0]), 32'h00);
         chk($sformatf("stuck%0d_joy2", k), 32'(j2[0]), 32'h00);
      end

      // reset in the middle of a select=0 frame
      stuck[0] = 1'b0;
      pat1[0]  = 16'h7FFF;
      pat0[0]  = 16'hF7FF;
      wait_valid(0, n);
      chk("pre_abort_joy1", 32'(j1[0]), 32'h41);
      n = -1;
      for (int k = 1; k <= 5000; k++) begin
         @(posedge clk);
         #1;
         if (!jsel[0]) begin
            n = k;
            break;
         end
      end
      chk("sel0_seen", 32'(n > 0), 32'd1);
      p = 1'b0;
      r = 0;
      for (int k = 0; k < 4000 && r < 9; k++) begin
         @(posedge clk);
         #1;
         if (jclk[0] && !p) r++;
         p = jclk[0];
      end
      chk("reach_bit9", 32'(r), 32'd9);
      repeat (150) @(posedge clk);
      #1;
      chk("bit9_sel", 32'(jsel[0]), 32'd0);
      rstn[0] = 1'b0;
      @(posedge clk);
      #1;
      rstn[0] = 1'b1;
      chk("abort_joy1", 32'(j1[0]), 32'h00);
      chk("abort_joy2", 32'(j2[0]), 32'h00);
      chk("abort_valid", 32'(jv[0]), 32'd0);
      chk("abort_sel", 32'(jsel[0]), 32'd1);
      chk("abort_load", 32'(jload[0]), 32'd1);
      wait_valid(0, n);
      chk("restart_time", 32'(n), 32'd7600);
      chk("restart_joy1", 32'(j1[0]), 32'h41);
      chk("restart_joy2", 32'(j2[0]), 32'h00);

      // CLK_DIV=1 instance
      wait_valid(1, n);
      chk("fast_seen", 32'(n > 0 && n <= 76), 32'd1);
      wait_valid(1, n);
      chk("fast_period", 32'(n), 32'd76);
      chk("fast_joy1", 32'(j1[1]), 32'h41);
      chk("fast_joy2", 32'(j2[1]), 32'h00);
      @(posedge clk);
      #1;
      chk("fast_valid_width", 32'(jv[1]), 32'd0);

      // protocol checker results
      chk("proto_a", 32'(vio[0]), 32'd0);
      chk("proto_b", 32'(vio[1]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
